// File: rtl/init_tracker.sv
// Per-channel init state trackers feeding a round-robin event queue that
// drains through a single valid/ready output register.

module init_tracker_ch #(
  parameter int TMO_CYCLES = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       done_i,
  input  logic       clear_i,
  output logic       init_o,
  output logic       init_nxt_o,
  output logic       not_init_o,
  output logic       err_o,
  output logic       evt_o,
  output logic [1:0] evt_code_o
);
  typedef enum logic [1:0] {S_NOT_INIT, S_BUSY, S_INIT, S_ERR} state_e;

  // Counter holds k after k cycles in BUSY, so the timeout fires while it
  // reads TMO_CYCLES-1 and ERR lands exactly TMO_CYCLES cycles after entry.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q, not_init_q, err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_o      = 1'b0;
    evt_code_o = 2'b00;
    case (state_q)
      S_NOT_INIT: begin
        if (start_i) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i) begin
          state_d    = S_NOT_INIT;
          evt_o      = 1'b1;
          evt_code_o = 2'b11;
        end else if (done_i) begin
          state_d    = S_INIT;
          evt_o      = 1'b1;
          evt_code_o = 2'b01;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = S_ERR;
          evt_o      = 1'b1;
          evt_code_o = 2'b10;
        end
      end
      S_INIT, S_ERR: begin
        if (clear_i) begin
          state_d    = S_NOT_INIT;
          evt_o      = 1'b1;
          evt_code_o = 2'b11;
        end
      end
      default: state_d = S_NOT_INIT;
    endcase
  end

  assign init_nxt_o = (state_d == S_INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_NOT_INIT;
      cnt_q      <= '0;
      init_q     <= 1'b0;
      not_init_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_q     <= (state_d == S_INIT);
      not_init_q <= (state_d == S_NOT_INIT);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign init_o     = init_q;
  assign not_init_o = not_init_q;
  assign err_o      = err_q;
endmodule

module init_tracker #(
  parameter  int NUM_CH     = 4,
  parameter  int TMO_CYCLES = 255,
  parameter  int CNT_W      = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [NUM_CH-1:0] done_i,
  input  logic [NUM_CH-1:0] clear_i,
  output logic [NUM_CH-1:0] init_o,
  output logic [NUM_CH-1:0] not_init_o,
  output logic [NUM_CH-1:0] err_o,
  output logic              all_init_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic [1:0]        evt_code_o,
  output logic              evt_ovf_o
);
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [1:0]      code;
  } evt_t;

  logic [NUM_CH-1:0]      ch_evt, init_nxt;
  logic [NUM_CH-1:0][1:0] ch_code;
  logic [NUM_CH-1:0]      pend_q, pend_d;
  logic [NUM_CH-1:0][1:0] pcode_q, pcode_d;
  logic                   ovf_q, ovf_d, vld_q, vld_d, all_init_q, all_init_d;
  evt_t                   out_q, out_d;
  logic [CH_W-1:0]        rr_q, rr_d, idx, gnt;
  logic                   load_en, found;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    init_tracker_ch #(
      .TMO_CYCLES (TMO_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i[g]),
      .done_i     (done_i[g]),
      .clear_i    (clear_i[g]),
      .init_o     (init_o[g]),
      .init_nxt_o (init_nxt[g]),
      .not_init_o (not_init_o[g]),
      .err_o      (err_o[g]),
      .evt_o      (ch_evt[g]),
      .evt_code_o (ch_code[g])
    );
  end

  always_comb begin
    pend_d     = pend_q;
    pcode_d    = pcode_q;
    ovf_d      = ovf_q;
    vld_d      = vld_q;
    out_d      = out_q;
    rr_d       = rr_q;
    all_init_d = &init_nxt;
    load_en    = !vld_q || evt_ready_i;
    found      = 1'b0;
    gnt        = '0;
    idx        = '0;

    // rr_q is the first channel to look at: one past the last grant.
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(rr_q) + i) % NUM_CH);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end

    if (load_en) begin
      vld_d = found;
      if (found) begin
        out_d.ch     = gnt;
        out_d.code   = pcode_q[gnt];
        pend_d[gnt]  = 1'b0;
        rr_d         = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
      end
    end

    // Checking pend_d (post-load) lets an event racing its own load stay
    // pending without counting as an overwrite.
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_evt[c]) begin
        if (pend_d[c]) ovf_d = 1'b1;
        pend_d[c]  = 1'b1;
        pcode_d[c] = ch_code[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      pcode_q    <= '0;
      ovf_q      <= 1'b0;
      vld_q      <= 1'b0;
      out_q      <= '0;
      rr_q       <= '0;
      all_init_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pcode_q    <= pcode_d;
      ovf_q      <= ovf_d;
      vld_q      <= vld_d;
      out_q      <= out_d;
      rr_q       <= rr_d;
      all_init_q <= all_init_d;
    end
  end

  assign all_init_o  = all_init_q;
  assign evt_valid_o = vld_q;
  assign evt_ch_o    = out_q.ch;
  assign evt_code_o  = out_q.code;
  assign evt_ovf_o   = ovf_q;
endmodule

// File: doc/init_tracker.md
INIT_TRACKER -- requirements
Module: init_tracker

Interface
REQ-001 Parameter NUM_CH, default 4, number of tracked channels (1..16).
REQ-002 Parameter TMO_CYCLES, default 255, cycles allowed in BUSY before timeout (1..2**CNT_W-1).
REQ-003 Parameter CNT_W, default 8, timeout counter width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 start_i  in  NUM_CH  per-channel request to begin initialization.
REQ-008 done_i  in  NUM_CH  per-channel initialization-complete indication.
REQ-009 clear_i  in  NUM_CH  per-channel return to NOT_INIT.
REQ-010 init_o  out  NUM_CH  channel is in INIT.
REQ-011 not_init_o  out  NUM_CH  channel is in NOT_INIT.
REQ-012 err_o  out  NUM_CH  channel is in ERR.
REQ-013 all_init_o  out  1  all channels are in INIT.
REQ-014 evt_valid_o  out  1  an event is presented.
REQ-015 evt_ready_i  in  1  consumer accepts the event.
REQ-016 evt_ch_o  out  max(1,$clog2(NUM_CH))  channel index of the presented event.
REQ-017 evt_code_o  out  2  event code: 01 INIT reached, 10 timeout error, 11 cleared.
REQ-018 evt_ovf_o  out  1  sticky flag: an unconsumed event was overwritten.

Function
REQ-019 Each channel SHALL run an independent FSM with states NOT_INIT, BUSY, INIT and ERR; all outputs are registered.
REQ-020 NOT_INIT and start_i: next state BUSY, timeout counter loads 0.
REQ-021 BUSY: the counter increments every cycle; done_i moves to INIT; the counter reaching TMO_CYCLES without done_i moves to ERR.
REQ-022 done_i in the same cycle the counter reaches TMO_CYCLES: INIT wins, no error.
REQ-023 clear_i in BUSY, INIT or ERR: next state NOT_INIT; clear_i has priority over start_i and done_i.
REQ-024 clear_i in NOT_INIT: no state change and no event.
REQ-025 start_i in BUSY, INIT or ERR: ignored; ERR is left only by clear_i.
REQ-026 done_i outside BUSY: ignored.
REQ-027 Each transition into INIT (code 01), into ERR (10) or out of BUSY/INIT/ERR by clear (11) SHALL set that channel's pending flag and store its code one cycle after the causing input.
REQ-028 A new event on a channel whose pending flag is already set SHALL overwrite the stored code and set evt_ovf_o.
REQ-029 evt_ovf_o SHALL clear only on reset.
REQ-030 Output stage is a single register; when empty, or when a handshake occurs (evt_valid_o and evt_ready_i), it SHALL load the next pending channel, searching round-robin from the channel after the last one granted.
REQ-031 Loading a channel into the output stage SHALL clear its pending flag in the same cycle.
REQ-032 Loading SHALL happen at the earliest one cycle after the pending flag is set, so minimum latency from input to evt_valid_o is 2 cycles.
REQ-033 A new event on a channel being loaded in the same cycle SHALL remain pending and SHALL NOT set evt_ovf_o.
REQ-034 evt_ch_o and evt_code_o SHALL stay stable while evt_valid_o=1 and evt_ready_i=0.
REQ-035 With evt_ready_i held at 1 and events pending, the block SHALL deliver one event per cycle.
REQ-036 all_init_o SHALL equal the AND of init_o and update in the same cycle as init_o.

Reset
REQ-037 While rst=1, asynchronously: all channels NOT_INIT (not_init_o all ones, init_o=0, err_o=0), all_init_o=0, counters=0.
REQ-038 While rst=1, asynchronously: pending flags=0, evt_valid_o=0, evt_ch_o=0, evt_code_o=0, evt_ovf_o=0, round-robin pointer=0.
REQ-039 Reset mid-BUSY or during a stalled handshake SHALL abort it; no event is emitted for the abort.

Verification
REQ-040 start_i[0] pulse, done_i[0] 10 cycles later -> init_o[0]=1; evt ch 0, code 01.
REQ-041 start_i[1] pulse, no done, TMO_CYCLES=255 -> err_o[1]=1 exactly 255 cycles after BUSY entry; evt ch 1, code 10; start_i[1] then ignored until clear_i[1].
REQ-042 done_i[2] in the same cycle as the timeout -> init_o[2]=1, err_o[2]=0.
REQ-043 All 4 channels reach INIT in one cycle, evt_ready_i=1 -> all_init_o=1; events delivered ch 0,1,2,3 on consecutive cycles.
REQ-044 evt_ready_i=0 and two events on channel 3 -> second code retained, evt_ovf_o=1, evt_ch_o/evt_code_o stable during stall.
REQ-045 clear_i and start_i together on channel 0 while in INIT -> NOT_INIT, code 11; then rst mid-BUSY -> all outputs at reset values.
